// File: rtl/sram_axi_bridge_pkg.sv
// Shared encodings for the SRAM-bus to AXI4 bridge: FSM states, AXI constants and size helpers.
package sram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4,
    DONE  = 3'd5
  } bridgeState_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // AXI AxSIZE is log2(bytes); the bus encoding already matches, so reserved codes pass through unchanged.
  function automatic logic [2:0] axiSize(input logic [1:0] size);
    case (size)
      SIZE_BYTE: axiSize = 3'b000;
      SIZE_HALF: axiSize = 3'b001;
      SIZE_WORD: axiSize = 3'b010;
      default:   axiSize = {1'b0, size};
    endcase
  endfunction

  function automatic logic respIsError(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Responder end of the cache SRAM-like request/ready bus; each request becomes one single-beat AXI4 transfer.
// Fixed AXI fields (id, len, burst, wlast, lock, cache, prot) are tied off by the enclosing wrapper.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_strobe,
  input  logic               s_rw,
  input  logic [A_WIDTH-1:0] s_addr,
  input  logic [1:0]         s_size,
  input  logic [3:0]         s_wen,
  input  logic [31:0]        s_wdata,
  output logic [31:0]        s_rdata,
  output logic               s_ready,
  output logic [A_WIDTH-1:0] araddr,
  output logic [2:0]         arsize,
  output logic               arvalid,
  input  logic               arready,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rvalid,
  output logic               rready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [2:0]         awsize,
  output logic               awvalid,
  input  logic               awready,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wvalid,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready,
  output logic               bus_err
);

  bridgeState_t state_q, state_d;

  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]         size_q, size_d;
  logic [3:0]         wen_q, wen_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               awDone_q, awDone_d;
  logic               wDone_q, wDone_d;
  logic               busErr_q, busErr_d;

  logic awFire;
  logic wFire;
  logic rFire;
  logic bFire;

  assign awFire = awvalid && awready;
  assign wFire  = wvalid && wready;
  assign rFire  = rvalid && rready;
  assign bFire  = bvalid && bready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      wen_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      awDone_q <= 1'b0;
      wDone_q  <= 1'b0;
      busErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      awDone_q <= awDone_d;
      wDone_q  <= wDone_d;
      busErr_q <= busErr_d;
    end
  end

  // AW and W complete independently; WR_B waits for whichever handshake lands last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (s_strobe) begin
          state_d = s_rw ? WR_AW : RD_A;
        end
      end
      RD_A: begin
        if (arready) begin
          state_d = RD_D;
        end
      end
      RD_D: begin
        if (rvalid) begin
          state_d = DONE;
        end
      end
      WR_AW: begin
        if ((awDone_q || awFire) && (wDone_q || wFire)) begin
          state_d = WR_B;
        end
      end
      WR_B: begin
        if (bvalid) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The request is captured only in IDLE; master inputs are ignored for the rest of the transfer.
  always_comb begin
    addr_d   = addr_q;
    size_d   = size_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    awDone_d = awDone_q;
    wDone_d  = wDone_q;
    busErr_d = busErr_q;
    if (state_q == IDLE && s_strobe) begin
      addr_d   = s_addr;
      size_d   = s_size;
      wen_d    = s_wen;
      wdata_d  = s_wdata;
      awDone_d = 1'b0;
      wDone_d  = 1'b0;
    end
    if (awFire) begin
      awDone_d = 1'b1;
    end
    if (wFire) begin
      wDone_d = 1'b1;
    end
    if (rFire) begin
      rdata_d = rdata;
      if (respIsError(rresp)) begin
        busErr_d = 1'b1;
      end
    end
    if (bFire && respIsError(bresp)) begin
      busErr_d = 1'b1;
    end
  end

  always_comb begin
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    s_ready = 1'b0;
    case (state_q)
      RD_A:  arvalid = 1'b1;
      RD_D:  rready  = 1'b1;
      WR_AW: begin
        awvalid = !awDone_q;
        wvalid  = !wDone_q;
      end
      WR_B:  bready  = 1'b1;
      DONE:  s_ready = 1'b1;
      default: ;
    endcase
  end

  assign araddr  = addr_q;
  assign arsize  = axiSize(size_q);
  assign awaddr  = addr_q;
  assign awsize  = axiSize(size_q);
  assign wdata   = wdata_q;
  assign wstrb   = wen_q;
  assign s_rdata = rdata_q;
  assign bus_err = busErr_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the initial block plays both the cache master and the AXI slave,
// with a scoreboard queue holding each request's expected AXI fields and read data.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_strobe;
  logic        s_rw;
  logic [31:0] s_addr;
  logic [1:0]  s_size;
  logic [3:0]  s_wen;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        bus_err;

  always #5 clk = ~clk;

  sram_axi_bridge #(.A_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_strobe(s_strobe), .s_rw(s_rw), .s_addr(s_addr), .s_size(s_size),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .bus_err(bus_err)
  );

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t expQ[$];

  int checks   = 0;
  int errors   = 0;
  int cycle    = 0;
  int reqStart = 0;
  int arCount  = 0;
  int awCount  = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (arvalid && arready) arCount <= arCount + 1;
      if (awvalid && awready) awCount <= awCount + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    cycle++;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                               input logic [3:0] wen, input logic [31:0] wd, input logic [31:0] rd);
    txn_t t;
    t.rw = rw; t.addr = addr; t.size = size; t.wen = wen; t.wdata = wd; t.rdata = rd;
    expQ.push_back(t);
    s_strobe = 1'b1;
    s_rw     = rw;
    s_addr   = addr;
    s_size   = size;
    s_wen    = wen;
    s_wdata  = wd;
    reqStart = cycle;
  endtask

  task automatic releaseStrobe();
    s_strobe = 1'b0;
    s_addr   = 32'hFFFF_FFFC;
    s_wdata  = 32'h5555_AAAA;
    tick();
    checkOutput("readyPulseOneCycle", 64'(s_ready), 64'(0));
    tick();
    checkOutput("idleNoAxi", 64'(arvalid | awvalid | wvalid), 64'(0));
  endtask

  task automatic serveRead(input int arWait, input int rWait, input logic [1:0] resp);
    txn_t t;
    int n;
    t = '0;
    n = 0;
    while (arvalid !== 1'b1 && n < 20) begin tick(); n++; end
    checkOutput("arvalidSeen", 64'(arvalid), 64'(1));
    checkOutput("noAwDuringRead", 64'(awvalid | wvalid), 64'(0));
    if (expQ.size() > 0) t = expQ[0];
    checkOutput("araddr", 64'(araddr), 64'(t.addr));
    checkOutput("arsize", 64'(arsize), 64'({1'b0, t.size}));
    repeat (arWait) begin tick(); checkOutput("arvalidHold", 64'(arvalid), 64'(1)); end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    checkOutput("arvalidDrop", 64'(arvalid), 64'(0));
    checkOutput("rreadySeen", 64'(rready), 64'(1));
    repeat (rWait) begin tick(); checkOutput("rreadyHold", 64'(rready), 64'(1)); end
    rvalid = 1'b1; rdata = t.rdata; rresp = resp;
    tick();
    rvalid = 1'b0; rdata = 32'h0BAD_F00D; rresp = 2'b00;
    checkOutput("readReady", 64'(s_ready), 64'(1));
    checkOutput("rreadyDrop", 64'(rready), 64'(0));
    if (expQ.size() > 0) t = expQ.pop_front();
    checkOutput("readData", 64'(s_rdata), 64'(t.rdata));
  endtask

  task automatic serveWrite(input int awWait, input int wWait, input int bWait, input logic [1:0] resp);
    txn_t t;
    int n;
    int maxW;
    t = '0;
    n = 0;
    while (awvalid !== 1'b1 && wvalid !== 1'b1 && n < 20) begin tick(); n++; end
    checkOutput("awvalidRaised", 64'(awvalid), 64'(1));
    checkOutput("wvalidRaised", 64'(wvalid), 64'(1));
    checkOutput("noArDuringWrite", 64'(arvalid), 64'(0));
    if (expQ.size() > 0) t = expQ[0];
    checkOutput("awaddr", 64'(awaddr), 64'(t.addr));
    checkOutput("awsize", 64'(awsize), 64'({1'b0, t.size}));
    checkOutput("wdata", 64'(wdata), 64'(t.wdata));
    checkOutput("wstrb", 64'(wstrb), 64'(t.wen));
    maxW = (awWait > wWait) ? awWait : wWait;
    for (int k = 0; k <= maxW; k++) begin
      awready = (k == awWait);
      wready  = (k == wWait);
      tick();
      awready = 1'b0;
      wready  = 1'b0;
      if (k < maxW) begin
        checkOutput("awvalidHold", 64'(awvalid), 64'(k < awWait));
        checkOutput("wvalidHold", 64'(wvalid), 64'(k < wWait));
        checkOutput("breadyEarly", 64'(bready), 64'(0));
      end
    end
    checkOutput("breadySeen", 64'(bready), 64'(1));
    checkOutput("validsDropped", 64'(awvalid | wvalid), 64'(0));
    repeat (bWait) begin
      tick();
      checkOutput("breadyHold", 64'(bready), 64'(1));
      checkOutput("readyBeforeB", 64'(s_ready), 64'(0));
    end
    bvalid = 1'b1; bresp = resp;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    checkOutput("writeReady", 64'(s_ready), 64'(1));
    checkOutput("breadyDrop", 64'(bready), 64'(0));
    if (expQ.size() > 0) void'(expQ.pop_front());
  endtask

  initial begin
    int n;
    int arBase;
    int awBase;
    rst = 1'b1;
    s_strobe = 1'b0; s_rw = 1'b0; s_addr = '0; s_size = '0; s_wen = '0; s_wdata = '0;
    arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;

    repeat (3) tick();
    checkOutput("resetValids", 64'({arvalid, rready, awvalid, wvalid, bready, s_ready}), 64'(0));
    checkOutput("resetRdata", 64'(s_rdata), 64'(0));
    checkOutput("resetBusErr", 64'(bus_err), 64'(0));
    rst = 1'b0;
    repeat (3) begin
      tick();
      checkOutput("idleNoStrobe", 64'(arvalid | awvalid | wvalid | s_ready), 64'(0));
    end

    // Read against a zero-wait slave
    applyStimulus(1'b0, 32'h0000_1040, 2'd2, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    serveRead(0, 0, 2'b00);
    checkOutput("readLatency", 64'(cycle - reqStart + 1), 64'(4));
    releaseStrobe();
    checkOutput("rdataHeld", 64'(s_rdata), 64'(32'hDEAD_BEEF));

    // Byte write, zero-wait
    applyStimulus(1'b1, 32'h1FAF_F010, 2'd0, 4'b0001, 32'h0000_0011, 32'h0);
    serveWrite(0, 0, 0, 2'b00);
    checkOutput("writeLatency", 64'(cycle - reqStart + 1), 64'(4));
    releaseStrobe();

    // W accepted three cycles before AW
    applyStimulus(1'b1, 32'h4000_0008, 2'd2, 4'b1111, 32'h1234_5678, 32'h0);
    serveWrite(3, 0, 1, 2'b00);
    releaseStrobe();

    // AW accepted before W
    applyStimulus(1'b1, 32'h4000_000C, 2'd1, 4'b1100, 32'hBEEF_0000, 32'h0);
    serveWrite(0, 2, 0, 2'b00);
    releaseStrobe();

    // Write-back then refill with strobe held through the ready cycle
    arBase = arCount;
    awBase = awCount;
    applyStimulus(1'b1, 32'h0000_2000, 2'd2, 4'b1111, 32'hCAFE_0001, 32'h0);
    serveWrite(0, 0, 0, 2'b00);
    applyStimulus(1'b0, 32'h0000_3000, 2'd2, 4'b0000, 32'h0, 32'h1357_9BDF);
    tick();
    checkOutput("b2bReadyPulse", 64'(s_ready), 64'(0));
    serveRead(0, 0, 2'b00);
    releaseStrobe();
    checkOutput("b2bOneAw", 64'(awCount - awBase), 64'(1));
    checkOutput("b2bOneAr", 64'(arCount - arBase), 64'(1));

    // Error response is sticky across later OKAY transfers
    applyStimulus(1'b0, 32'h0000_5000, 2'd1, 4'b0000, 32'h0, 32'hA5A5_5A5A);
    checkOutput("busErrBefore", 64'(bus_err), 64'(0));
    serveRead(1, 2, 2'b10);
    checkOutput("busErrSet", 64'(bus_err), 64'(1));
    releaseStrobe();
    applyStimulus(1'b1, 32'h0000_5004, 2'd1, 4'b0011, 32'h0000_ABCD, 32'h0);
    serveWrite(1, 1, 0, 2'b00);
    releaseStrobe();
    checkOutput("busErrStickyWrite", 64'(bus_err), 64'(1));
    applyStimulus(1'b0, 32'h0000_5008, 2'd2, 4'b0000, 32'h0, 32'h0F0F_F0F0);
    serveRead(0, 0, 2'b00);
    releaseStrobe();
    checkOutput("busErrStickyRead", 64'(bus_err), 64'(1));

    // Reset while waiting for read data
    applyStimulus(1'b0, 32'h0000_6000, 2'd2, 4'b0000, 32'h0, 32'h7777_7777);
    n = 0;
    while (arvalid !== 1'b1 && n < 20) begin tick(); n++; end
    checkOutput("rstArvalidSeen", 64'(arvalid), 64'(1));
    arready = 1'b1;
    tick();
    arready = 1'b0;
    checkOutput("rstInRdD", 64'(rready), 64'(1));
    rst = 1'b1;
    s_strobe = 1'b0;
    tick();
    checkOutput("rstDropsValids", 64'({arvalid, rready, awvalid, wvalid, bready, s_ready}), 64'(0));
    checkOutput("rstClearsBusErr", 64'(bus_err), 64'(0));
    expQ.delete();
    rst = 1'b0;
    tick();
    checkOutput("rstIdle", 64'(arvalid | awvalid | s_ready), 64'(0));
    applyStimulus(1'b0, 32'h0000_6004, 2'd2, 4'b0000, 32'h0, 32'h89AB_CDEF);
    serveRead(0, 0, 2'b00);
    checkOutput("postRstLatency", 64'(cycle - reqStart + 1), 64'(4));
    releaseStrobe();
    checkOutput("postRstBusErr", 64'(bus_err), 64'(0));

    checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
